pid_cfg_loader: RTL
===================

# pid_cfg_loader

SPI-to-register configuration controller for the PID core. It samples the external SPI pins in the `clk` domain and frames 24-bit write transactions. Each valid frame is decoded into an address/data pair and committed to a small coefficient register file (Kp, Ki, Kd, setpoint) that feeds the PID datapath. It also supplies the transaction abort timer the input-only SPI receiver lacks.

## Interface
- `WORD_BITS`, 16: width of each config register and of the frame data field.
- `NREGS`, 4: number of config registers; valid addresses are 0..`NREGS`-1.
- `MOSI_INV`, 1: when 1, the MOSI pin value is inverted before shifting.
- `TIMEOUT_CYCLES`, 1024: idle `clk` cycles inside a frame before abort (timeout build only).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `cs`  in  1  SPI chip select pin, active-low, asynchronous to `clk`.
- `sck`  in  1  SPI clock pin, asynchronous.
- `mosi`  in  1  SPI data pin, asynchronous.
- `regs_flat`  out  `NREGS`*`WORD_BITS`  register file; reg n occupies bits [n*`WORD_BITS` +: `WORD_BITS`].
- `wr_strobe`  out  1  one-cycle pulse on each register commit.
- `wr_addr`  out  4  address of the last commit; valid while `wr_strobe` is high and held afterwards.
- `busy`  out  1  high while in SHIFT or WAIT_CS.
- `err`  out  1  one-cycle pulse on a rejected or aborted frame.

## Operation
- Frame format, MSB first: [23:20] address, [19:16] reserved (ignored), [15:0] data. `FRAME_BITS` = 24 when `WORD_BITS`=16; in general it is 8+`WORD_BITS`.
- `cs`, `sck` and `mosi` pass through 2-flop synchronizers. The synchronized `sck` is edge-detected, and data is sampled on the synchronized falling edge. The sampled bit is `mosi_s` XOR `MOSI_INV`.
- IDLE:
  - `cs_s` falling goes to SHIFT with the shift register and bit counter cleared.
  - `cs_s` low at reset exit does not start a frame; the block waits for `cs_s` high first.
- SHIFT:
  - Each sampled fall shifts one bit in and increments the counter.
  - On the `FRAME_BITS`-th bit, the address is checked:
    - address < `NREGS`: write the data field into that register, pulse `wr_strobe`, update `wr_addr`, go to WAIT_CS.
    - address >= `NREGS`: pulse `err`, no write, go to WAIT_CS.
  - `cs_s` rising before `FRAME_BITS` bits (short frame): pulse `err`, no write, go to IDLE. A rising `cs_s` with zero bits received is not an error.
- WAIT_CS:
  - Further `sck` edges are ignored; an overrun is not an error.
  - `cs_s` rising goes to IDLE.
- Simultaneous events: when `cs_s` rises in the same cycle as a sampled falling edge, `cs` wins. That bit is discarded and the frame is treated as short.
- The register file changes only on a commit. Multiple frames may be sent back-to-back with `cs` pulsed high for at least 3 `clk` cycles between them.

## Timing
- Pin-to-sample latency is 3 `clk` cycles: two synchronizer stages plus the edge register.
- `wr_strobe` and `regs_flat` update 1 `clk` after the last bit is sampled.
- `err` asserts 1 cycle after the detecting condition.
- Requirement: `sck` high and low phases each last at least 3 `clk` periods. `mosi` is stable from 1 `clk` before the falling edge until 3 `clk` after it.
- Reset values: `regs_flat` all zero, `wr_strobe` 0, `wr_addr` 0, `busy` 0, `err` 0, state IDLE.
- Synchronizer `cs` flops reset to 1 (deasserted).
- Reset mid-frame discards the partial frame without pulsing `err`.

## Configuration
- Macro `PID_CFG_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(`TIMEOUT_CYCLES`+1) clears in IDLE and on every sampled `sck` edge, and counts in SHIFT.
  - Reaching `TIMEOUT_CYCLES` pulses `err`, discards the frame and goes to WAIT_CS.
  - The timer is inactive in WAIT_CS.
- Undefined: no counter is built, and a frame ends only on bit count or `cs`.

## Structure
- Package `pid_cfg_pkg` holds:
  - the state enum (IDLE, SHIFT, WAIT_CS);
  - `FRAME_BITS`;
  - the address field position;
  - register address constants `REG_KP`=0, `REG_KI`=1, `REG_KD`=2, `REG_SP`=3.
- Sub-module `spi_pin_sync`: 2-flop synchronizers for the three pins plus the `sck` fall detector. Outputs are `cs_s`, `mosi_s` and `sck_fall`; its parameter is the `cs` reset value.

## Test plan
- Valid write: with `MOSI_INV`=1, shift 0x101234 inverted on the pin at 4 `clk` per `sck` half-period. Expect one `wr_strobe`, `wr_addr`=1, reg1=0x1234, other registers 0, `err` never high.
- Bad address: frame 0x50ABCD → `err` pulse, no `wr_strobe`, `regs_flat` unchanged.
- Short frame: 12 bits then `cs` high → `err` pulse, no write; a following valid frame 0x30BEEF still sets reg3=0xBEEF.
- Overrun: 30 bits starting 0x00FFFF → reg0=0xFFFF committed once, extra bits ignored, no `err`.
- Timeout (macro defined, `TIMEOUT_CYCLES`=64): 8 bits, then `sck` stalls for 100 cycles with `cs` low → `err` pulse at cycle 64 after the last edge. Then `cs` high, and the next frame is accepted normally.
- Reset mid-frame: assert `reset` after 10 bits → all outputs return to reset values, no `err`. Bits clocked while `cs` stays low are ignored until `cs` is seen high.

Source files
------------

// File: rtl/pid_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pid_cfg_pkg
// Description : Shared types and constants for the PID configuration loader:
//               FSM state encoding, SPI frame geometry and register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package pid_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  localparam int ADDR_BITS         = 4;
  localparam int RSVD_BITS         = 4;
  localparam int DEFAULT_WORD_BITS = 16;

  // Frame is [addr | reserved | data], MSB first.
  localparam int FRAME_BITS = ADDR_BITS + RSVD_BITS + DEFAULT_WORD_BITS;
  localparam int ADDR_LSB   = FRAME_BITS - ADDR_BITS;

  localparam logic [ADDR_BITS-1:0] REG_KP = 4'd0;
  localparam logic [ADDR_BITS-1:0] REG_KI = 4'd1;
  localparam logic [ADDR_BITS-1:0] REG_KD = 4'd2;
  localparam logic [ADDR_BITS-1:0] REG_SP = 4'd3;

  // Frame geometry for a non-default data width.
  function automatic int frame_bits_for(input int word_bits);
    return ADDR_BITS + RSVD_BITS + word_bits;
  endfunction

  function automatic int addr_lsb_for(input int word_bits);
    return RSVD_BITS + word_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pid_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pid_cfg_loader_if
// Description : SPI pins in, register file and status out. The master side
//               drives the pins; the slave side is the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface pid_cfg_loader_if
  import pid_cfg_pkg::*;
#(
  parameter int NREGS     = 4,
  parameter int WORD_BITS = 16
);

  logic                       cs;
  logic                       sck;
  logic                       mosi;
  logic [NREGS*WORD_BITS-1:0] regs_flat;
  logic                       wr_strobe;
  logic [ADDR_BITS-1:0]       wr_addr;
  logic                       busy;
  logic                       err;

  modport master (
    output cs, sck, mosi,
    input  regs_flat, wr_strobe, wr_addr, busy, err
  );

  modport slave (
    input  cs, sck, mosi,
    output regs_flat, wr_strobe, wr_addr, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Two-flop synchronizers for cs/sck/mosi plus a registered
//               falling-edge detector on the synchronized sck.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
  parameter logic CS_RESET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sck,
  input  logic mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sck_fall
);

  logic cs_meta;
  logic sck_meta;
  logic sck_s;
  logic sck_d;
  logic mosi_meta;

  // Synchronizer chains and the sck history flop used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta   <= CS_RESET;
      cs_s      <= CS_RESET;
      sck_meta  <= 1'b0;
      sck_s     <= 1'b0;
      sck_d     <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_s      <= cs_meta;
      sck_meta  <= sck;
      sck_s     <= sck_meta;
      sck_d     <= sck_s;
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign sck_fall = sck_d & ~sck_s;

endmodule
`default_nettype wire

// File: rtl/pid_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : pid_cfg_loader
// Description : Frames SPI write transactions sampled in the clk domain and
//               commits address/data pairs into the PID coefficient registers.
//               Optional frame abort timer enabled by PID_CFG_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_cfg_loader
  import pid_cfg_pkg::*;
#(
  parameter int WORD_BITS      = 16,
  parameter int NREGS          = 4,
  parameter int MOSI_INV       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  pid_cfg_loader_if.slave  bus
);

  localparam int FBITS = frame_bits_for(WORD_BITS);
  localparam int ALSB  = addr_lsb_for(WORD_BITS);
  localparam int CNT_W = $clog2(FBITS + 1);

  logic cs_s;
  logic mosi_s;
  logic sck_fall;

  spi_pin_sync #(
    .CS_RESET (1'b1)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .cs       (bus.cs),
    .sck      (bus.sck),
    .mosi     (bus.mosi),
    .cs_s     (cs_s),
    .mosi_s   (mosi_s),
    .sck_fall (sck_fall)
  );

  state_t               r_state;
  state_t               w_next;
  logic [FBITS-1:0]     r_shreg;
  logic [FBITS-1:0]     w_shifted;
  logic [CNT_W-1:0]     r_bitcnt;
  logic [ADDR_BITS-1:0] w_addr;
  logic [WORD_BITS-1:0] w_data;
  logic                 w_addr_ok;
  logic                 w_bit;
  logic [1:0]           r_primed;
  logic                 r_cs_hi_seen;
  logic                 w_clear;
  logic                 w_shift;
  logic                 w_commit;
  logic                 w_reject;
  logic                 w_tmo;
  logic                 r_wr_strobe;
  logic                 r_err;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [WORD_BITS-1:0] r_regs [NREGS];

  assign w_bit     = mosi_s ^ (MOSI_INV != 0);
  assign w_shifted = {r_shreg[FBITS-2:0], w_bit};
  assign w_addr    = w_shifted[ALSB +: ADDR_BITS];
  assign w_data    = w_shifted[WORD_BITS-1:0];
  assign w_addr_ok = int'(w_addr) < NREGS;

`ifdef PID_CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Idle timer: runs only in SHIFT and restarts on every sampled sck edge.
  always_ff @(posedge clk) begin
    if (reset || (r_state != SHIFT) || sck_fall) begin
      r_tmo <= '0;
    end else if (!w_tmo) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign w_tmo = (r_tmo == TMO_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_tmo          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath controls; cs release outranks a same-cycle bit.
  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_cs_hi_seen && !cs_s) begin
          w_next  = SHIFT;
          w_clear = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          w_next   = IDLE;
          w_reject = (r_bitcnt != '0);
        end else if (w_tmo) begin
          w_next   = WAIT_CS;
          w_reject = 1'b1;
        end else if (sck_fall) begin
          w_shift = 1'b1;
          if (r_bitcnt == CNT_W'(FBITS - 1)) begin
            w_next   = WAIT_CS;
            w_commit = w_addr_ok;
            w_reject = !w_addr_ok;
          end
        end
      end
      WAIT_CS: begin
        if (cs_s) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Frame shifter, cs arming, register file and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_primed     <= 2'b00;
      r_cs_hi_seen <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_err        <= 1'b0;
      r_wr_addr    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      // cs_s holds its reset value for two cycles; only a real high arms IDLE.
      r_primed     <= {r_primed[0], 1'b1};
      r_cs_hi_seen <= r_cs_hi_seen | (r_primed[1] & cs_s);
      r_wr_strobe  <= w_commit;
      r_err        <= w_reject;
      if (w_clear) begin
        r_shreg  <= '0;
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_shreg  <= w_shifted;
        r_bitcnt <= r_bitcnt + CNT_W'(1);
      end
      if (w_commit) begin
        r_wr_addr <= w_addr;
        for (int i = 0; i < NREGS; i++) begin
          if (w_addr == ADDR_BITS'(i)) begin
            r_regs[i] <= w_data;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign bus.regs_flat[gi*WORD_BITS +: WORD_BITS] = r_regs[gi];
  end

  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire
